// File: rtl/dmem_wait.sv
// dmem_wait: single-port word memory answering each access after a fixed number of wait states.
// Byte loads/stores (LDRB/STRB) are built only when DMEM_BYTE_ACCESS_EN is defined.
module dmem_wait #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        bytesel,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        ready,
    output logic        err,
    output logic [15:0] stall_cnt
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             we_q;
    logic [31:0]      a_q, wd_q;
    logic             latch_c;
    logic             commit_c;
    logic             ready_n, err_n;
    logic [31:0]      rd_n;

    logic [31:0]      acc_a_c, acc_wd_c;
    logic             acc_we_c;
    logic [IDX_W-1:0] acc_idx_c;
    logic             acc_oob_c;
    logic [31:0]      acc_word_c;
    logic [31:0]      load_c, store_c;

    logic [31:0]      mem [DEPTH_WORDS];

    // In IDLE the access is described by the live inputs, afterwards by the latched copy.
    assign acc_a_c    = (state == IDLE) ? a  : a_q;
    assign acc_wd_c   = (state == IDLE) ? wd : wd_q;
    assign acc_we_c   = (state == IDLE) ? we : we_q;
    assign acc_idx_c  = acc_a_c[IDX_W+1:2];
    assign acc_oob_c  = |acc_a_c[31:IDX_W+2];
    assign acc_word_c = mem[acc_idx_c];

`ifdef DMEM_BYTE_ACCESS_EN
    logic bytesel_q;
    logic acc_byte_c;

    assign acc_byte_c = (state == IDLE) ? bytesel : bytesel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bytesel_q <= 1'b0;
        end else if (latch_c) begin
            bytesel_q <= bytesel;
        end
    end

    // Little-endian lane select for byte loads, read-modify-write merge for byte stores.
    always_comb begin
        load_c  = acc_word_c;
        store_c = acc_wd_c;
        if (acc_byte_c) begin
            load_c  = {24'd0, acc_word_c[{acc_a_c[1:0], 3'b000} +: 8]};
            store_c = acc_word_c;
            store_c[{acc_a_c[1:0], 3'b000} +: 8] = acc_wd_c[7:0];
        end
    end
`else
    logic unused_byte;

    assign load_c      = acc_word_c;
    assign store_c     = acc_wd_c;
    assign unused_byte = ^{bytesel, acc_a_c[1:0]};
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        latch_c  = 1'b0;
        commit_c = 1'b0;
        ready_n  = 1'b0;
        err_n    = 1'b0;
        rd_n     = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch_c = 1'b1;
                    cnt_n   = CNT_W'(WAIT_CYCLES);
                    state_n = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                commit_c = acc_we_c && !acc_oob_c;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (state_n == DONE) begin
            ready_n = 1'b1;
            err_n   = acc_oob_c;
            rd_n    = (acc_oob_c || acc_we_c) ? 32'd0 : load_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
            rd    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= ready_n;
            err   <= err_n;
            rd    <= rd_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q <= 1'b0;
            a_q  <= '0;
            wd_q <= '0;
        end else if (latch_c) begin
            we_q <= we;
            a_q  <= a;
            wd_q <= wd;
        end
    end

    // Storage is never cleared; a store lands at the end of its DONE cycle.
    always_ff @(posedge clk) begin
        if (commit_c && !reset) begin
            mem[acc_idx_c] <= store_c;
        end
    end

    assign stall = (state == WAIT) || ((state == IDLE) && req && (WAIT_CYCLES != 0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_wait.sv
// Self-checking bench for dmem_wait: wait-state timing, word/byte data, range faults,
// reset abort, zero-wait operation and stall counter saturation.
module tb_dmem_wait;
`ifdef DMEM_BYTE_ACCESS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif
    localparam int DEPTH = 64;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        reset, req, we, bytesel;
    logic [31:0] a, wd, rd;
    logic        stall, ready, err;
    logic [15:0] stall_cnt;

    logic        rst0, req0, we0;
    logic [31:0] a0, wd0, rd0;
    logic        stall0, ready0, err0;
    logic [15:0] stall_cnt0;

    logic        rst15, req15;
    logic [31:0] rd15;
    logic        stall15, ready15, err15;
    logic [15:0] stall_cnt15;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_stall = 0;
    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    dmem_wait #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .bytesel(bytesel), .a(a), .wd(wd),
        .rd(rd), .stall(stall), .ready(ready), .err(err), .stall_cnt(stall_cnt));

    dmem_wait #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst0), .req(req0), .we(we0), .bytesel(1'b0), .a(a0), .wd(wd0),
        .rd(rd0), .stall(stall0), .ready(ready0), .err(err0), .stall_cnt(stall_cnt0));

    dmem_wait #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(15)) u_dut15 (
        .clk(clk), .reset(rst15), .req(req15), .we(1'b0), .bytesel(1'b0), .a(32'h0), .wd(32'h0),
        .rd(rd15), .stall(stall15), .ready(ready15), .err(err15), .stall_cnt(stall_cnt15));

    // Reference behaviour of one access against the word-array model.
    function automatic void mdl_access(input logic w, input logic bs, input logic [31:0] addr,
                                       input logic [31:0] data, output logic [31:0] exp_rd,
                                       output logic exp_err);
        logic [31:0] word;
        int unsigned idx;
        int lane;
        idx  = int'(addr >> 2);
        lane = int'(addr & 32'h3);
        exp_rd = 32'h0;
        if (idx >= DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        word = mdl[idx];
        if (w) begin
            if (bs && BYTE_EN) word[lane*8 +: 8] = data[7:0];
            else word = data;
            mdl[idx] = word;
        end else begin
            exp_rd = (bs && BYTE_EN) ? ((word >> (lane*8)) & 32'hFF) : word;
        end
    endfunction

    // Issue one access on the main DUT; inputs are scrambled once it is accepted.
    task automatic access(input logic w, input logic bs, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] o_rd, output logic o_err, output int lat, output int nstall,
                          output logic acc_stall, output logic done_stall);
        @(negedge clk);
        req = 1'b1; we = w; bytesel = bs; a = addr; wd = data;
        #1 acc_stall = stall;
        @(posedge clk);
        #1;
        req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        bytesel = 1'($urandom_range(0, 1)); a = $urandom; wd = $urandom;
        lat = 0; nstall = 0; o_rd = '0; o_err = 1'b0; done_stall = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready) begin
                lat = k; o_rd = rd; o_err = err; done_stall = stall;
                break;
            end
            if (stall) nstall++;
        end
        req = 1'b0;
        exp_stall += W + 1;
        if (lat == 0) begin
            n_checks++;
            $display("FAIL access_timeout: no ready within 40 cycles for a=%h", addr);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; rst0 = 1'b1; rst15 = 1'b1;
        req = 1'b0; we = 1'b0; bytesel = 1'b0; a = '0; wd = '0;
        req0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0; req15 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_rd: got %h expected 0", rd); else n_pass++;
        n_checks++; if (stall_cnt !== 16'h0) $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); else n_pass++;
        n_checks++; if (stall_cnt15 !== 16'h0) $display("FAIL reset_stall_cnt15: got %h expected 0", stall_cnt15); else n_pass++;
        reset = 1'b0; rst0 = 1'b0;
        exp_stall = 0;
    endtask

    task automatic test_word_basic;
        logic [31:0] r; logic e, s0, sd; int lat, ns;
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat, ns, s0, sd);
        n_checks++; if (lat != W + 1) $display("FAIL store_latency: got %0d expected %0d", lat, W + 1); else n_pass++;
        n_checks++; if (ns != W) $display("FAIL store_wait_stalls: got %0d expected %0d", ns, W); else n_pass++;
        n_checks++; if (s0 !== 1'b1) $display("FAIL accept_stall: got %b expected 1", s0); else n_pass++;
        n_checks++; if (sd !== 1'b0) $display("FAIL done_stall: got %b expected 0", sd); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL store_err: got %b expected 0", e); else n_pass++;
        access(1'b0, 1'b0, 32'h10, 32'h0, r, e, lat, ns, s0, sd);
        n_checks++; if (lat != W + 1) $display("FAIL load_latency: got %0d expected %0d", lat, W + 1); else n_pass++;
        n_checks++; if (r !== 32'hDEADBEEF) $display("FAIL load_data: got %h expected deadbeef", r); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL load_err: got %b expected 0", e); else n_pass++;
        @(negedge clk);
        n_checks++; if (rd !== 32'h0 || ready !== 1'b0) $display("FAIL rd_idle: got rd=%h ready=%b expected 0/0", rd, ready); else n_pass++;
        n_checks++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL stall_cnt_basic: got %0d expected %0d", stall_cnt, exp_stall); else n_pass++;
    endtask

    task automatic test_byte;
        logic [31:0] r; logic e, s0, sd; int lat, ns;
        logic [31:0] exp_word, exp_byte;
        exp_word = BYTE_EN ? 32'h1122AA44 : 32'h000000AA;
        exp_byte = BYTE_EN ? 32'h00000011 : 32'h000000AA;
        access(1'b1, 1'b0, 32'h20, 32'h11223344, r, e, lat, ns, s0, sd);
        access(1'b1, 1'b1, 32'h21, 32'h000000AA, r, e, lat, ns, s0, sd);
        access(1'b0, 1'b0, 32'h20, 32'h0, r, e, lat, ns, s0, sd);
        n_checks++; if (r !== exp_word) $display("FAIL strb_merge: got %h expected %h", r, exp_word); else n_pass++;
        access(1'b0, 1'b1, 32'h23, 32'h0, r, e, lat, ns, s0, sd);
        n_checks++; if (r !== exp_byte) $display("FAIL ldrb_lane3: got %h expected %h", r, exp_byte); else n_pass++;
        access(1'b0, 1'b0, 32'h23, 32'h0, r, e, lat, ns, s0, sd);
        n_checks++; if (r !== exp_word) $display("FAIL word_align: got %h expected %h", r, exp_word); else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [31:0] r; logic e, s0, sd; int lat, ns;
        access(1'b1, 1'b0, 32'h0, 32'hCAFEF00D, r, e, lat, ns, s0, sd);
        access(1'b1, 1'b0, 32'h100, 32'h12345678, r, e, lat, ns, s0, sd);
        n_checks++; if (e !== 1'b1) $display("FAIL oob_store_err: got %b expected 1", e); else n_pass++;
        n_checks++; if (lat != W + 1) $display("FAIL oob_latency: got %0d expected %0d", lat, W + 1); else n_pass++;
        access(1'b0, 1'b0, 32'h100, 32'h0, r, e, lat, ns, s0, sd);
        n_checks++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL oob_load: got err=%b rd=%h expected 1/0", e, r); else n_pass++;
        access(1'b0, 1'b0, 32'h0, 32'h0, r, e, lat, ns, s0, sd);
        n_checks++; if (r !== 32'hCAFEF00D) $display("FAIL oob_no_alias: got %h expected cafef00d", r); else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] r; logic e, s0, sd; int lat, ns;
        access(1'b1, 1'b0, 32'h8, 32'h00000077, r, e, lat, ns, s0, sd);
        @(negedge clk);
        req = 1'b1; we = 1'b1; bytesel = 1'b0; a = 32'h8; wd = 32'h5;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) $display("FAIL mid_wait_stall: got %b expected 1", stall); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (stall_cnt !== 16'h0) $display("FAIL abort_stall_cnt: got %h expected 0", stall_cnt); else n_pass++;
        n_checks++; if (stall !== 1'b0 || ready !== 1'b0) $display("FAIL abort_outputs: got stall=%b ready=%b expected 0/0", stall, ready); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0;
        repeat (4) @(negedge clk);
        n_checks++; if (ready !== 1'b0) $display("FAIL abort_no_ready: got %b expected 0", ready); else n_pass++;
        access(1'b0, 1'b0, 32'h8, 32'h0, r, e, lat, ns, s0, sd);
        n_checks++; if (r !== 32'h77) $display("FAIL abort_no_commit: got %h expected 00000077", r); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] r, er, addr, data; logic e, ee, s0, sd, w, bs; int lat, ns;
        for (int i = 0; i < DEPTH; i++) begin
            data = $urandom;
            access(1'b1, 1'b0, 32'(i * 4), data, r, e, lat, ns, s0, sd);
            mdl_access(1'b1, 1'b0, 32'(i * 4), data, er, ee);
        end
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 63));
            data = $urandom;
            access(w, bs, addr, data, r, e, lat, ns, s0, sd);
            mdl_access(w, bs, addr, data, er, ee);
            n_checks++; if (e !== ee) $display("FAIL rand_err[%0d]: got %b expected %b a=%h", i, e, ee, addr); else n_pass++;
            if (!w) begin
                n_checks++; if (r !== er) $display("FAIL rand_rd[%0d]: got %h expected %h a=%h bs=%b", i, r, er, addr, bs); else n_pass++;
            end
        end
        n_checks++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL stall_cnt_rand: got %0d expected %0d", stall_cnt, exp_stall); else n_pass++;
    endtask

    task automatic test_wait0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; a0 = 32'h40; wd0 = 32'h0BADF00D;
        #1;
        n_checks++; if (stall0 !== 1'b0) $display("FAIL w0_accept_stall: got %b expected 0", stall0); else n_pass++;
        @(negedge clk);
        n_checks++; if (ready0 !== 1'b1 || err0 !== 1'b0) $display("FAIL w0_store_ready: got ready=%b err=%b expected 1/0", ready0, err0); else n_pass++;
        we0 = 1'b0; a0 = 32'h40; wd0 = $urandom;
        @(negedge clk);
        n_checks++; if (ready0 !== 1'b0 || stall0 !== 1'b0) $display("FAIL w0_idle: got ready=%b stall=%b expected 0/0", ready0, stall0); else n_pass++;
        @(negedge clk);
        n_checks++; if (ready0 !== 1'b1 || rd0 !== 32'h0BADF00D) $display("FAIL w0_load: got ready=%b rd=%h expected 1/0badf00d", ready0, rd0); else n_pass++;
        req0 = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_cnt0 !== 16'h0) $display("FAIL w0_stall_cnt: got %h expected 0", stall_cnt0); else n_pass++;
    endtask

    // Held request with 15 wait states: 16 stalled cycles out of every 17.
    task automatic test_saturate;
        @(negedge clk);
        rst15 = 1'b0;
        @(negedge clk);
        req15 = 1'b1;
        repeat (17 * 10) @(posedge clk);
        #1;
        n_checks++; if (stall_cnt15 !== 16'd160) $display("FAIL sat_partial: got %0d expected 160", stall_cnt15); else n_pass++;
        repeat (17 * 4090) @(posedge clk);
        #1;
        n_checks++; if (stall_cnt15 !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", stall_cnt15); else n_pass++;
        repeat (170) @(posedge clk);
        #1;
        n_checks++; if (stall_cnt15 !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", stall_cnt15); else n_pass++;
        n_checks++; if (err15 !== 1'b0) $display("FAIL sat_err: got %b expected 0", err15); else n_pass++;
        req15 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_basic();
        test_byte();
        test_out_of_range();
        test_reset_mid_wait();
        test_random();
        test_wait0();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
